// File: rtl/mult16_pp_gen.sv
// Sequential 16x16 unsigned partial-product generator: streams shifted rows over a
// valid/ready handshake and accumulates them into the exact 32-bit product.
module mult16_pp_gen #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        pp_valid,
    input  logic        pp_ready,
    output logic [31:0] pp_row,
    output logic [3:0]  pp_idx,
    output logic        pp_last,
    output logic        prod_valid,
    output logic [31:0] prod,
    output logic        busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] prod_q, prod_d;
    logic        prod_valid_q, prod_valid_d;

    logic        emit_s;
    logic        accept_s;
    logic        fire_s;
    logic        zero_short_s;
    logic        last_s;
    logic [3:0]  first_idx_s;
    logic [31:0] row_s;
    logic [31:0] sum_s;

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) r = i[3:0];
        end
        return r;
    endfunction

    function automatic logic [3:0] highest_set(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) r = i[3:0];
        end
        return r;
    endfunction

    // Lowest set bit strictly above cur; caller guarantees one exists.
    function automatic logic [3:0] next_set(input logic [15:0] v, input logic [3:0] cur);
        logic [3:0] r;
        r = cur;
        for (int i = 15; i >= 0; i--) begin
            if (v[i] && (i[3:0] > cur)) r = i[3:0];
        end
        return r;
    endfunction

    // Handshake qualifiers and row datapath shared by all processes.
    always_comb begin
        emit_s       = (state_q == ST_EMIT);
        accept_s     = in_valid & ~emit_s;
        fire_s       = emit_s & pp_ready;
        zero_short_s = SKIP_ZERO && (in_b == 16'd0);
        first_idx_s  = SKIP_ZERO ? lowest_set(in_b) : 4'd0;
        if (SKIP_ZERO) begin
            last_s = emit_s & (idx_q == highest_set(b_q));
        end else begin
            last_s = emit_s & (idx_q == 4'd15);
        end
        if (emit_s && b_q[idx_q]) begin
            row_s = {16'd0, a_q} << idx_q;
        end else begin
            row_s = 32'd0;
        end
        sum_s = acc_q + row_s;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && !zero_short_s) begin
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (fire_s && last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        in_ready   = ~emit_s;
        pp_valid   = emit_s;
        busy       = emit_s;
        pp_row     = row_s;
        pp_idx     = emit_s ? idx_q : 4'd0;
        pp_last    = last_s;
        prod_valid = prod_valid_q;
        prod       = prod_q;
    end

    // Operand, index, accumulator and product next-state.
    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        prod_d       = prod_q;
        prod_valid_d = 1'b0;
        if (accept_s) begin
            a_d   = in_a;
            b_d   = in_b;
            idx_d = first_idx_s;
            acc_d = 32'd0;
            if (zero_short_s) begin
                prod_d       = 32'd0;
                prod_valid_d = 1'b1;
            end else begin
                prod_valid_d = 1'b0;
            end
        end else if (fire_s) begin
            acc_d = sum_s;
            if (last_s) begin
                prod_d       = sum_s;
                prod_valid_d = 1'b1;
            end else if (SKIP_ZERO) begin
                idx_d = next_set(b_q, idx_q);
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end else begin
            prod_valid_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q          <= 16'd0;
            b_q          <= 16'd0;
            idx_q        <= 4'd0;
            acc_q        <= 32'd0;
            prod_q       <= 32'd0;
            prod_valid_q <= 1'b0;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            prod_q       <= prod_d;
            prod_valid_q <= prod_valid_d;
        end
    end

endmodule

// File: tb/tb_mult16_pp_gen.sv
// Directed self-checking bench for mult16_pp_gen, one instance per SKIP_ZERO setting.
module tb_mult16_pp_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid0, in_valid1;
    logic [15:0] in_a, in_b;
    logic        pp_ready;

    logic        in_ready0, pp_valid0, pp_last0, prod_valid0, busy0;
    logic [31:0] pp_row0, prod0;
    logic [3:0]  pp_idx0;
    logic        in_ready1, pp_valid1, pp_last1, prod_valid1, busy1;
    logic [31:0] pp_row1, prod1;
    logic [3:0]  pp_idx1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult16_pp_gen #(.SKIP_ZERO(1'b0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .pp_valid(pp_valid0), .pp_ready(pp_ready),
        .pp_row(pp_row0), .pp_idx(pp_idx0), .pp_last(pp_last0),
        .prod_valid(prod_valid0), .prod(prod0), .busy(busy0)
    );

    mult16_pp_gen #(.SKIP_ZERO(1'b1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .pp_valid(pp_valid1), .pp_ready(pp_ready),
        .pp_row(pp_row1), .pp_idx(pp_idx1), .pp_last(pp_last1),
        .prod_valid(prod_valid1), .prod(prod1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; afterwards we observe that cycle's outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_row;
        logic [31:0] sav_row;
        logic [3:0]  sav_idx;
        logic        sav_last;
        logic        stalled;
        int          hs;

        rst = 1'b1; in_valid0 = 1'b0; in_valid1 = 1'b0;
        in_a = 16'd0; in_b = 16'd0; pp_ready = 1'b1;
        tick(); tick();
        chk("rst_in_ready", {31'd0, in_ready0}, 32'd1);
        chk("rst_pp_valid", {31'd0, pp_valid0}, 32'd0);
        chk("rst_pp_row", pp_row0, 32'd0);
        chk("rst_pp_idx", {28'd0, pp_idx0}, 32'd0);
        chk("rst_pp_last", {31'd0, pp_last0}, 32'd0);
        chk("rst_prod_valid", {31'd0, prod_valid0}, 32'd0);
        chk("rst_prod", prod0, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_in_ready1", {31'd0, in_ready1}, 32'd1);
        rst = 1'b0;
        tick();

        // Full rows
        in_a = 16'hFFFF; in_b = 16'hFFFF; in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_row = 32'h0000FFFF << k;
            chk("full_valid", {31'd0, pp_valid0}, 32'd1);
            chk("full_idx", {28'd0, pp_idx0}, k);
            chk("full_row", pp_row0, exp_row);
            chk("full_last", {31'd0, pp_last0}, (k == 15) ? 32'd1 : 32'd0);
            chk("full_in_ready", {31'd0, in_ready0}, 32'd0);
            chk("full_no_pulse", {31'd0, prod_valid0}, 32'd0);
            tick();
        end
        chk("full_prod_valid", {31'd0, prod_valid0}, 32'd1);
        chk("full_prod", prod0, 32'hFFFE0001);
        chk("full_in_ready_L1", {31'd0, in_ready0}, 32'd1);
        chk("full_pp_valid_L1", {31'd0, pp_valid0}, 32'd0);
        tick();
        chk("full_pulse_one", {31'd0, prod_valid0}, 32'd0);
        chk("full_prod_hold", prod0, 32'hFFFE0001);

        // Backpressure
        in_a = 16'd3; in_b = 16'd5; in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        hs = 0; stalled = 1'b0;
        sav_row = 32'd0; sav_idx = 4'd0; sav_last = 1'b0;
        for (int cyc = 0; cyc < 64 && hs < 16; cyc++) begin
            pp_ready = (cyc % 2 == 0);
            if (stalled) begin
                chk("bp_hold_row", pp_row0, sav_row);
                chk("bp_hold_idx", {28'd0, pp_idx0}, {28'd0, sav_idx});
                chk("bp_hold_last", {31'd0, pp_last0}, {31'd0, sav_last});
            end
            chk("bp_valid", {31'd0, pp_valid0}, 32'd1);
            if (pp_ready) begin
                exp_row = (hs == 0) ? 32'd3 : (hs == 2) ? 32'd12 : 32'd0;
                chk("bp_idx", {28'd0, pp_idx0}, hs);
                chk("bp_row", pp_row0, exp_row);
                chk("bp_last", {31'd0, pp_last0}, (hs == 15) ? 32'd1 : 32'd0);
                hs++;
                stalled = 1'b0;
            end else begin
                sav_row = pp_row0; sav_idx = pp_idx0; sav_last = pp_last0;
                stalled = 1'b1;
            end
            tick();
        end
        pp_ready = 1'b1;
        chk("bp_handshakes", hs, 32'd16);
        chk("bp_prod_valid", {31'd0, prod_valid0}, 32'd1);
        chk("bp_prod", prod0, 32'd15);
        tick();

        // Sparse skip
        in_a = 16'h1234; in_b = 16'h8001; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        chk("skip_v0", {31'd0, pp_valid1}, 32'd1);
        chk("skip_idx0", {28'd0, pp_idx1}, 32'd0);
        chk("skip_row0", pp_row1, 32'h00001234);
        chk("skip_last0", {31'd0, pp_last1}, 32'd0);
        tick();
        chk("skip_v1", {31'd0, pp_valid1}, 32'd1);
        chk("skip_idx1", {28'd0, pp_idx1}, 32'd15);
        chk("skip_row1", pp_row1, 32'h091A0000);
        chk("skip_last1", {31'd0, pp_last1}, 32'd1);
        tick();
        chk("skip_done_valid", {31'd0, pp_valid1}, 32'd0);
        chk("skip_prod_valid", {31'd0, prod_valid1}, 32'd1);
        chk("skip_prod", prod1, 32'h091A1234);
        tick();

        // Zero multiplier
        in_a = 16'hABCD; in_b = 16'h0000; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        chk("zero_pp_valid", {31'd0, pp_valid1}, 32'd0);
        chk("zero_prod_valid", {31'd0, prod_valid1}, 32'd1);
        chk("zero_prod", prod1, 32'd0);
        chk("zero_in_ready", {31'd0, in_ready1}, 32'd1);
        tick();
        chk("zero_pulse_one", {31'd0, prod_valid1}, 32'd0);
        chk("zero_pp_valid2", {31'd0, pp_valid1}, 32'd0);

        // Reset mid-operation
        in_a = 16'd7; in_b = 16'hFFFF; in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("mid_busy_pre", {31'd0, busy0}, 32'd1);
        chk("mid_idx_pre", {28'd0, pp_idx0}, 32'd5);
        rst = 1'b1;
        #1;
        chk("mid_pp_valid", {31'd0, pp_valid0}, 32'd0);
        chk("mid_in_ready", {31'd0, in_ready0}, 32'd1);
        chk("mid_prod", prod0, 32'd0);
        chk("mid_busy", {31'd0, busy0}, 32'd0);
        tick();
        chk("mid_no_pulse", {31'd0, prod_valid0}, 32'd0);
        rst = 1'b0;
        tick();
        chk("mid_no_pulse2", {31'd0, prod_valid0}, 32'd0);
        in_a = 16'd2; in_b = 16'd3; in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        for (int k = 0; k < 16; k++) tick();
        chk("post_rst_prod_valid", {31'd0, prod_valid0}, 32'd1);
        chk("post_rst_prod", prod0, 32'd6);
        tick();

        // Back-to-back with ignored input while busy
        in_a = 16'd5; in_b = 16'd3; in_valid0 = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            in_a = (k % 2 == 0) ? 16'hDEAD : 16'h0F0F;
            in_b = (k % 2 == 0) ? 16'hBEEF : 16'hFFFF;
            chk("b2b_in_ready_busy", {31'd0, in_ready0}, 32'd0);
            tick();
        end
        in_a = 16'h0010; in_b = 16'h0100;
        chk("b2b_prod1_valid", {31'd0, prod_valid0}, 32'd1);
        chk("b2b_prod1", prod0, 32'd15);
        chk("b2b_in_ready_L1", {31'd0, in_ready0}, 32'd1);
        tick();
        in_valid0 = 1'b0;
        chk("b2b_first_valid", {31'd0, pp_valid0}, 32'd1);
        chk("b2b_first_idx", {28'd0, pp_idx0}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            if (k == 8) chk("b2b_row8", pp_row0, 32'h00001000);
            if (k == 0) chk("b2b_row0", pp_row0, 32'd0);
            tick();
        end
        chk("b2b_prod2_valid", {31'd0, prod_valid0}, 32'd1);
        chk("b2b_prod2", prod0, 32'h00001000);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
